// File: rtl/riscv_alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops and an iterative one-bit-per-cycle
// shifter, with a registered valid/ready result port towards memory/writeback.
module riscv_alu_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      AluCtl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic [4:0]      rd_o
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    state_t            state_r, state_n;
    logic [XLEN-1:0]   shreg_r, shreg_n;
    logic [SHW-1:0]    cnt_r, cnt_n;
    logic [3:0]        shop_r, shop_n;
    logic [4:0]        shrd_r, shrd_n;
    logic              valid_r, valid_n;
    logic [XLEN-1:0]   result_r, result_n;
    logic              zero_r, zero_n;
    logic [4:0]        rd_r, rd_n;

    logic              ready_s;
    logic              accept_s;
    logic              is_shift_s;
    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   alu_res_s;
    logic [XLEN-1:0]   shstep_s;
    logic              wr_s;
    logic [XLEN-1:0]   wr_val_s;
    logic [4:0]        wr_rd_s;

    assign ready_s  = (state_r == ST_IDLE) && (!valid_r || ready_i);
    assign accept_s = valid_i && ready_s;
    assign shamt_s  = op_b_i[SHW-1:0];

    assign ready_o  = ready_s;
    assign valid_o  = valid_r;
    assign result_o = result_r;
    assign zero_o   = zero_r;
    assign rd_o     = rd_r;

    // Single-cycle ALU result; a shift by zero simply passes operand A through.
    always_comb begin
        alu_res_s  = '0;
        is_shift_s = 1'b0;
        case (AluCtl_i)
            OP_ADD:  alu_res_s = op_a_i + op_b_i;
            OP_SUB:  alu_res_s = op_a_i - op_b_i;
            OP_AND:  alu_res_s = op_a_i & op_b_i;
            OP_OR:   alu_res_s = op_a_i | op_b_i;
            OP_XOR:  alu_res_s = op_a_i ^ op_b_i;
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift_s = 1'b1;
                alu_res_s  = op_a_i;
            end
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
            default: alu_res_s = '0;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        case (shop_r)
            OP_SLL:  shstep_s = {shreg_r[XLEN-2:0], 1'b0};
            OP_SRL:  shstep_s = {1'b0, shreg_r[XLEN-1:1]};
            OP_SRA:  shstep_s = {shreg_r[XLEN-1], shreg_r[XLEN-1:1]};
            default: shstep_s = shreg_r;
        endcase
    end

    // Next-state, shifter bookkeeping and output-register update.
    always_comb begin
        state_n  = state_r;
        shreg_n  = shreg_r;
        cnt_n    = cnt_r;
        shop_n   = shop_r;
        shrd_n   = shrd_r;
        wr_s     = 1'b0;
        wr_val_s = '0;
        wr_rd_s  = 5'd0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_shift_s && (shamt_s != '0)) begin
                        state_n = ST_SHIFT;
                        shreg_n = op_a_i;
                        cnt_n   = shamt_s;
                        shop_n  = AluCtl_i;
                        shrd_n  = rd_i;
                    end else begin
                        wr_s     = 1'b1;
                        wr_val_s = alu_res_s;
                        wr_rd_s  = rd_i;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_n = shstep_s;
                cnt_n   = cnt_r - {{(SHW-1){1'b0}}, 1'b1};
                if (cnt_r == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_n  = ST_IDLE;
                    wr_s     = 1'b1;
                    wr_val_s = shstep_s;
                    wr_rd_s  = shrd_r;
                end else begin
                    state_n = ST_SHIFT;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A held result stays put under backpressure; zero flag tracks the written value.
        if (wr_s) begin
            valid_n  = 1'b1;
            result_n = wr_val_s;
            zero_n   = (wr_val_s == '0);
            rd_n     = wr_rd_s;
        end else begin
            valid_n  = valid_r && !ready_i;
            result_n = result_r;
            zero_n   = zero_r;
            rd_n     = rd_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r  <= ST_IDLE;
            shreg_r  <= '0;
            cnt_r    <= '0;
            shop_r   <= 4'd0;
            shrd_r   <= 5'd0;
            valid_r  <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b1;
            rd_r     <= 5'd0;
        end else begin
            state_r  <= state_n;
            shreg_r  <= shreg_n;
            cnt_r    <= cnt_n;
            shop_r   <= shop_n;
            shrd_r   <= shrd_n;
            valid_r  <= valid_n;
            result_r <= result_n;
            zero_r   <= zero_n;
            rd_r     <= rd_n;
        end
    end

endmodule

// File: tb/tb_riscv_alu_exec.sv
// Scoreboard bench for riscv_alu_exec: directed scenarios plus randomized ops checked
// against an arithmetic reference model.
module tb_riscv_alu_exec;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  AluCtl_i = 4'd0;
    logic [31:0] op_a_i = 32'd0;
    logic [31:0] op_b_i = 32'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic        zero_o;
    logic [4:0]  rd_o;

    logic [36:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    riscv_alu_exec #(.XLEN(32), .SHW(5)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
        .AluCtl_i(AluCtl_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .zero_o(zero_o), .rd_o(rd_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = b % 32;
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return 32'($signed(a) >>> sh);
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Present one op until accepted; optionally wiggle ready_i while waiting.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input bit rnd);
        int n;
        AluCtl_i = c; op_a_i = a; op_b_i = b; rd_i = r; valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (ready_o) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'(ready_o), 32'd1);
                break;
            end
            @(posedge clk_i); #1;
            if (rnd) ready_i = 1'($urandom_range(0, 1));
        end
        if (ready_o) sb.push_back({r, model(c, a, b)});
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        if (rnd) ready_i = 1'($urandom_range(0, 1));
    endtask

    // Count stall cycles after a shift accept while junk is presented on the inputs.
    task automatic stall_check(input string nm, input int exp_n, input logic [31:0] exp_res);
        int n;
        valid_i = 1'b1; AluCtl_i = 4'd1; op_a_i = $urandom; op_b_i = $urandom; rd_i = 5'd31;
        n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        chk({nm, "_stall"}, 32'(n), 32'(exp_n));
        chk({nm, "_valid"}, 32'(valid_o), 32'd1);
        chk({nm, "_res"}, result_o, exp_res);
    endtask

    // Monitor: every consumed result is popped from the scoreboard and compared.
    always @(negedge clk_i) begin
        if (rstn_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(valid_o), 32'd0);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("mon_result", result_o, e[31:0]);
                chk("mon_rd", 32'(rd_o), 32'(e[36:32]));
                chk("mon_zero", 32'(zero_o), 32'(e[31:0] == 32'd0));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start;
        idle(3);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd1);
        chk("rst_rd", 32'(rd_o), 32'd0);
        rstn_i = 1'b1;
        idle(1);
        chk("rst_ready", 32'(ready_o), 32'd1);

        issue(4'd1, 32'h0000_0005, 32'hFFFF_FFFB, 5'd3, 1'b0);
        chk("add_valid", 32'(valid_o), 32'd1);
        chk("add_result", result_o, 32'd0);
        chk("add_zero", 32'(zero_o), 32'd1);
        chk("add_rd", 32'(rd_o), 32'd3);

        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b0);
        chk("slt", result_o, 32'd1);
        issue(4'd10, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b0);
        chk("sltu", result_o, 32'd0);
        issue(4'd2, 32'd3, 32'd5, 5'd6, 1'b0);
        chk("sub", result_o, 32'hFFFF_FFFE);
        idle(2);

        issue(4'd8, 32'h8000_0000, 32'h0000_0024, 5'd7, 1'b0);
        stall_check("sra4", 4, 32'hF800_0000);
        idle(2);
        issue(4'd6, 32'd1, 32'hFFFF_FFFF, 5'd9, 1'b0);
        stall_check("sll31", 31, 32'h8000_0000);
        idle(2);

        ready_i = 1'b0;
        issue(4'd4, 32'h0F0, 32'h00F, 5'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_result", result_o, 32'h0FF);
            chk("bp_ready", 32'(ready_o), 32'd0);
        end
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        issue(4'd1, 32'h100, 32'h23, 5'd11, 1'b0);
        chk("bp_next", result_o, 32'h123);
        idle(2);

        start = cyc;
        for (int i = 0; i < 8; i++) issue(4'd1, $urandom, $urandom, 5'(i + 16), 1'b0);
        chk("stream_cycles", 32'(cyc - start), 32'd8);
        idle(2);

        issue(4'd6, $urandom, 32'd20, 5'd12, 1'b0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rstn_i = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        void'(sb.pop_back());
        idle(2);
        rstn_i = 1'b1;
        idle(30);
        chk("midrst_noresult", 32'(valid_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd1);
        issue(4'd1, 32'd40, 32'd2, 5'd13, 1'b0);
        chk("midrst_add", result_o, 32'd42);
        idle(2);

        for (int i = 0; i < 300; i++)
            issue(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
        ready_i = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
        idle(2);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
